// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fft_pkg
// Description : Shared constants and helpers for the radix-5 FFT datapath.
//               Lane packing: lane j of a LANES*DW bus sits at [j*DW +: DW].
// Revision    : 1.0 - initial release
// ============================================================================
package fft_pkg;

    // Default width of one real or imaginary component
    localparam int c_DW_DEFAULT = 32;

    // Width of one complex sample (real + imaginary)
    function automatic int cplx_width(input int dw);
        return 2 * dw;
    endfunction

    // Least-significant bit position of lane j on a packed component bus
    function automatic int lane_lsb(input int lane, input int dw);
        return lane * dw;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fft_pipe_stage.sv
`default_nettype none
// ============================================================================
// Module      : fft_pipe_stage
// Description : One register stage of the elastic FFT pipeline buffer.
//               Holds valid, the packed complex sample and the frame-last tag.
// Revision    : 1.0 - initial release
// ============================================================================
module fft_pipe_stage
    import fft_pkg::*;
#(
    parameter int DW    = c_DW_DEFAULT,
    parameter int LANES = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_flush,
    input  logic                  i_load,
    input  logic                  i_valid,
    input  logic [LANES*DW-1:0]   i_re,
    input  logic [LANES*DW-1:0]   i_img,
    input  logic                  i_last,
    output logic                  o_valid,
    output logic [LANES*DW-1:0]   o_re,
    output logic [LANES*DW-1:0]   o_img,
    output logic                  o_last
);

    localparam int c_LW = LANES * DW;
    localparam int c_SW = LANES * cplx_width(DW);

    logic              r_valid;
    logic [c_SW-1:0]   r_sample;
    logic              r_last;

    // Stage register: reset clears everything, flush only drops valid,
    // payload is captured only when a valid sample arrives
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid  <= 1'b0;
            r_sample <= '0;
            r_last   <= 1'b0;
        end else if (i_flush) begin
            r_valid  <= 1'b0;
        end else if (i_load) begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_sample <= {i_re, i_img};
                r_last   <= i_last;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_re    = r_sample[c_SW-1 -: c_LW];
    assign o_img   = r_sample[c_LW-1:0];
    assign o_last  = r_last;

endmodule
`default_nettype wire

// File: rtl/fft_pipe_buf.sv
`default_nettype none
// ============================================================================
// Module      : fft_pipe_buf
// Description : Elastic valid/ready pipeline buffer of DEPTH stages carrying
//               LANES complex samples, with bubble collapse, frame-last tag,
//               synchronous flush and registered occupancy.
// Revision    : 1.0 - initial release
// ============================================================================
module fft_pipe_buf
    import fft_pkg::*;
#(
    parameter int DW    = c_DW_DEFAULT,
    parameter int LANES = 3,
    parameter int DEPTH = 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           flush,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [LANES*DW-1:0]            in_re,
    input  logic [LANES*DW-1:0]            in_img,
    input  logic                           in_last,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [LANES*DW-1:0]            out_re,
    output logic [LANES*DW-1:0]            out_img,
    output logic                           out_last,
    output logic [$clog2(DEPTH+1)-1:0]     occupancy
);

    localparam int c_LW = LANES * DW;
    localparam int c_OW = $clog2(DEPTH + 1);

    // Ready chain: w_rdy[s] says stage s may load this cycle.
    // Kept as an unpacked array so each element is an independent net.
    logic              w_rdy  [DEPTH+1];
    logic              w_v    [DEPTH];
    logic [c_LW-1:0]   w_re   [DEPTH];
    logic [c_LW-1:0]   w_img  [DEPTH];
    logic              w_last [DEPTH];

    logic              w_accept;
    logic              w_deliver;
    logic [c_OW-1:0]   r_occ;
    logic [c_OW-1:0]   w_occ_next;

    assign w_rdy[DEPTH] = out_ready;

    generate
        for (genvar s = 0; s < DEPTH; s++) begin : g_stage
            logic              w_src_v;
            logic [c_LW-1:0]   w_src_re;
            logic [c_LW-1:0]   w_src_img;
            logic              w_src_last;

            if (s == 0) begin : g_from_input
                assign w_src_v    = in_valid;
                assign w_src_re   = in_re;
                assign w_src_img  = in_img;
                assign w_src_last = in_last;
            end else begin : g_from_prev
                assign w_src_v    = w_v[s-1];
                assign w_src_re   = w_re[s-1];
                assign w_src_img  = w_img[s-1];
                assign w_src_last = w_last[s-1];
            end

            // An empty stage always loads, so bubbles collapse under stall
            assign w_rdy[s] = !w_v[s] || w_rdy[s+1];

            fft_pipe_stage #(
                .DW    (DW),
                .LANES (LANES)
            ) u_stage (
                .clk     (clk),
                .rst_n   (rst_n),
                .i_flush (flush),
                .i_load  (w_rdy[s]),
                .i_valid (w_src_v),
                .i_re    (w_src_re),
                .i_img   (w_src_img),
                .i_last  (w_src_last),
                .o_valid (w_v[s]),
                .o_re    (w_re[s]),
                .o_img   (w_img[s]),
                .o_last  (w_last[s])
            );
        end
    endgenerate

    assign in_ready  = w_rdy[0] && !flush;
    assign w_accept  = in_valid && in_ready;
    assign w_deliver = w_v[DEPTH-1] && out_ready;

    // Next occupancy: every move inside the chain conserves the count, so only
    // input accepts and output deliveries change it; flush empties the buffer
    always_comb begin
        w_occ_next = r_occ;
        if (flush) begin
            w_occ_next = '0;
        end else if (w_accept && !w_deliver) begin
            w_occ_next = r_occ + c_OW'(1);
        end else if (!w_accept && w_deliver) begin
            w_occ_next = r_occ - c_OW'(1);
        end
    end

    // Occupancy register, updated on the same edge as the stage valids
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_occ <= '0;
        end else begin
            r_occ <= w_occ_next;
        end
    end

    assign out_valid = w_v[DEPTH-1];
    assign out_re    = w_re[DEPTH-1];
    assign out_img   = w_img[DEPTH-1];
    assign out_last  = w_last[DEPTH-1];
    assign occupancy = r_occ;

endmodule
`default_nettype wire

// File: doc/fft_pipe_buf.md
# fft_pipe_buf

Parametrised elastic pipeline buffer for the radix-5 FFT datapath: carries LANES complex samples (re/img pairs of DW bits) through DEPTH register stages with a valid/ready handshake, frame-last tag, synchronous flush and occupancy reporting. It replaces fixed free-running lane registers between butterfly, twiddle-multiply and output stages. Unlike those registers, it can stall under back-pressure without losing data and collapses bubbles.

## Interface
Parameters:
- DW, 32: bit width of each real or imaginary component.
- LANES, 3: complex lanes per sample. Lane 0 is the "a" operand; lanes 1..LANES-1 are the "b" operands. Must be at least 1.
- DEPTH, 1: number of register stages. Must be at least 1.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, synchronous, active-low.
- flush  in  1  synchronous discard of all buffered samples.
- in_valid  in  1  upstream sample valid.
- in_ready  out  1  buffer accepts a sample this cycle.
- in_re  in  LANES*DW  real parts; lane j occupies bits [j*DW +: DW].
- in_img  in  LANES*DW  imaginary parts; same packing as in_re.
- in_last  in  1  last sample of an FFT frame.
- out_valid  out  1  head-stage sample valid.
- out_ready  in  1  downstream accepts.
- out_re  out  LANES*DW  head real parts.
- out_img  out  LANES*DW  head imaginary parts.
- out_last  out  1  head last tag.
- occupancy  out  $clog2(DEPTH+1)  number of valid stages.

## Operation
- Stage state: each stage s (0 = input side, DEPTH-1 = output) holds v[s], re[s], img[s] and last[s].
- Stage readiness: rdy[s] = !v[s] || rdy[s+1], with rdy[DEPTH] = out_ready.
- Input acceptance: in_ready = rdy[0] && !flush. A transfer occurs when in_valid && in_ready.
- Stage load: stage s loads from stage s-1 (stage 0 loads from the inputs) when rdy[s] is high.
  - The new v[s] equals the source valid.
  - Data and last load only when the source valid is 1; otherwise they hold their value.
- Bubble collapse: a valid sample moves forward whenever the next stage is empty, even while out_ready is low.
- Output mapping: out_valid = v[DEPTH-1]; out_re, out_img and out_last come straight from stage DEPTH-1 registers.
- Ordering and arithmetic: strict FIFO order, no reordering. Data passes bit-exact, with no arithmetic or sign handling.
- Flush:
  - On an edge with flush=1, all v[] clear to 0 and no input is captured; data registers hold.
  - flush has priority over a simultaneous transfer. A sample handshaken at the output on that edge counts as delivered.
- Reset: on an edge with rst_n=0, all v[] = 0, all data = 0, all last = 0, so every output reads 0.
  - Reset overrides flush and any in-flight transfer, including mid-stream.
- Occupancy: occupancy = popcount(v[]). It is registered-derived and updates the cycle after each edge's changes.
- Capacity: at most DEPTH samples are buffered. in_ready is low only when all stages are valid and out_ready=0, or when flush=1.

## Timing
- Latency: DEPTH cycles from an accepted input to out_valid, with the pipeline empty and out_ready=1.
- Throughput: one sample per cycle sustained while out_ready=1.
- Registered paths: out_* and occupancy are register outputs.
- Combinational path: in_ready depends combinationally on out_ready through the rdy chain (depth DEPTH). Integration must tolerate this path.
- Stall resume: after a stall, the first cycle with out_ready=1 both drains the head and accepts an input. Full rate resumes immediately, with no dead cycle.
- Reset release: in_ready=1 in the first cycle after rst_n returns high.
- Flush recovery: in_ready=1 again in the cycle after flush deasserts; occupancy reads 0 in that cycle.

## Structure
- Package fft_pkg holds:
  - the default DW constant;
  - a complex-sample width helper function;
  - the shared lane-packing convention, lane j at [j*DW +: DW].
- Sub-module fft_pipe_stage: one stage register carrying v, re, img and last, with load-enable, flush and rst_n. fft_pipe_buf instantiates it DEPTH times via generate and builds the rdy chain.

## Test plan
- Streaming, DEPTH=3, LANES=3, DW=32, out_ready=1:
  - stimulus: samples k=0..7 with lane j re=k*16+j, img=~(k*16+j), last on k=7;
  - required: out_valid first rises 3 cycles after the first accept, samples k=0..7 appear in order one per cycle, out_last set only on k=7.
- Back-pressure, DEPTH=3:
  - stimulus: in_valid=1 continuously while out_ready=0 for 6 cycles, then 1;
  - required: exactly 3 samples accepted, occupancy reaches 3, in_ready=0 while full; after release all samples drain in order with no loss or duplicates.
- Bubble collapse, DEPTH=4:
  - stimulus: send sample A, idle 2 cycles, send B, with out_ready=0;
  - required: occupancy=2 and in_ready=1; once out_ready=1, B is on the output the cycle after A.
- Flush mid-stream, DEPTH=3:
  - stimulus: 2 samples buffered, then flush=1 together with in_valid=1;
  - required: in_ready=0 during flush and nothing captured; next cycle out_valid=0 and occupancy=0; a sample sent afterwards emerges 3 cycles later.
- Reset mid-operation:
  - stimulus: pipeline full, drive rst_n=0 for one edge;
  - required: out_valid=0, out_re=out_img=0, out_last=0, occupancy=0 after that edge; in_ready=1 the cycle after release.
- Degenerate configuration, DEPTH=1, LANES=1, DW=16:
  - stimulus: alternate out_ready 1/0 under continuous in_valid;
  - required: 1-cycle latency, no loss, in_ready tracks !out_valid || out_ready.
